// File: rtl/key_input_capture_if.sv
// -----------------------------------------------------------------------------
// key_input_capture_if
//
// Avalon-MM slave bundle for the push-button reader.
//
// Signals:
//   avs_address    [1:0]   word address
//   avs_read               read strobe
//   avs_write              write strobe
//   avs_writedata  [31:0]  write data
//   avs_readdata   [31:0]  read data, valid one cycle after avs_read
//
// Modports:
//   master : the bus side (HPS bridge / testbench) driving the strobes
//   slave  : key_input_capture
// -----------------------------------------------------------------------------
interface key_input_capture_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/key_input_capture.sv
// -----------------------------------------------------------------------------
// key_input_capture
//
// Fabric-side reader for the board push-buttons. Each raw active-low KEY pin
// is synchronised (2 flops), debounced (a new level must persist for
// DEBOUNCE_CYCLES cycles) and press-edge captured. The HPS sees the result
// through a small Avalon-MM slave:
//   0 DATA     RO    debounced level, 1 = pressed
//   1 RELCAP   R/W1C release capture (KEY_RELEASE_CAPTURE_EN), else reads 0
//   2 IRQMASK  RW    interrupt enable per key
//   3 EDGECAP  R/W1C press capture
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  synchronous active-low reset
//   key_n          raw push-buttons, asynchronous, 0 = pressed
//   avs            Avalon-MM slave (key_input_capture_if.slave)
//   irq            level interrupt, |((edge | relcap) & mask), registered
//
// Build option:
//   KEY_RELEASE_CAPTURE_EN  when defined, address 1 becomes RELCAP, set on
//                           a debounced release and included in irq.
// -----------------------------------------------------------------------------
module key_input_capture #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    key_input_capture_if.slave  avs,
    output logic                irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_RELCAP = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_EDGE   = 2'd3;

    // Synchroniser
    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;

    // Debounce
    logic [NUM_KEYS-1:0]            key_in;
    logic [NUM_KEYS-1:0]            stable_q, stable_d;
    logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Edge detect / capture
    logic [NUM_KEYS-1:0] prev_q, prev_d;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] edge_q, edge_d;
    logic [NUM_KEYS-1:0] edge_clr;
    logic [NUM_KEYS-1:0] mask_q, mask_d;
    logic [NUM_KEYS-1:0] irq_src;

`ifdef KEY_RELEASE_CAPTURE_EN
    logic [NUM_KEYS-1:0] release_ev;
    logic [NUM_KEYS-1:0] relcap_q, relcap_d;
    logic [NUM_KEYS-1:0] relcap_clr;
`endif

    // Bus side
    logic [31:0] rd_mux;
    logic [31:0] readdata_q, readdata_d;
    logic        irq_q, irq_d;
    logic        wr_mask;
    logic        wr_edge;

    // Only the low NUM_KEYS bits of write data carry register content.
    generate
        if (NUM_KEYS < 32) begin : g_wdata_unused
            logic unused_wdata;
            assign unused_wdata = ^avs.avs_writedata[31:NUM_KEYS];
        end
    endgenerate

    // ---- stage: synchroniser (metastability filter on the async pins) ----
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
    end

    // ---- stage: debounce ----
    // Counter only runs while the synchronised level differs from the
    // accepted one; any return to the accepted level restarts it, so a
    // glitch shorter than DEBOUNCE_CYCLES never reaches stable.
    always_comb begin
        key_in   = ~sync2_q;
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_in[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = key_in[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // ---- stage: edge detect, capture registers, irq ----
    always_comb begin
        wr_mask  = avs.avs_write && (avs.avs_address == ADDR_MASK);
        wr_edge  = avs.avs_write && (avs.avs_address == ADDR_EDGE);
        edge_clr = wr_edge ? avs.avs_writedata[NUM_KEYS-1:0] : '0;

        prev_d = stable_q;
        press  = stable_q & ~prev_q;
        // A press in the same cycle as its W1C keeps the bit set.
        edge_d = (edge_q & ~edge_clr) | press;
        mask_d = wr_mask ? avs.avs_writedata[NUM_KEYS-1:0] : mask_q;

`ifdef KEY_RELEASE_CAPTURE_EN
        relcap_clr = (avs.avs_write && (avs.avs_address == ADDR_RELCAP)) ?
                     avs.avs_writedata[NUM_KEYS-1:0] : '0;
        release_ev = prev_q & ~stable_q;
        relcap_d   = (relcap_q & ~relcap_clr) | release_ev;
        irq_src    = (edge_q | relcap_q) & mask_q;
`else
        irq_src    = edge_q & mask_q;
`endif
        irq_d = |irq_src;
    end

    // ---- stage: read mux (samples pre-write state, so a read/W1C pair
    //      returns the value before the clear) ----
    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            ADDR_DATA:   rd_mux = 32'(stable_q);
`ifdef KEY_RELEASE_CAPTURE_EN
            ADDR_RELCAP: rd_mux = 32'(relcap_q);
`else
            ADDR_RELCAP: rd_mux = '0;
`endif
            ADDR_MASK:   rd_mux = 32'(mask_q);
            ADDR_EDGE:   rd_mux = 32'(edge_q);
            default:     rd_mux = '0;
        endcase
        readdata_d = avs.avs_read ? rd_mux : readdata_q;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            stable_q   <= '0;
            cnt_q      <= '0;
            prev_q     <= '0;
            edge_q     <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

`ifdef KEY_RELEASE_CAPTURE_EN
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            relcap_q <= '0;
        end else begin
            relcap_q <= relcap_d;
        end
    end
`endif

    assign avs.avs_readdata = readdata_q;
    assign irq              = irq_q;

endmodule

// File: tb/tb_key_input_capture.sv
// -----------------------------------------------------------------------------
// tb_key_input_capture
//
// Directed bench for key_input_capture with NUM_KEYS = 4, DEBOUNCE_CYCLES = 8.
// Inputs change and outputs are sampled on the falling clock edge. Cycle
// numbers in comments count rising edges after the negedge where the pin
// (or reset) changed. A debounced level changes on rising edge 10, the
// capture bit on edge 11 and irq on edge 12; a held DATA read shows the
// new level one edge after it changes.
// -----------------------------------------------------------------------------
module tb_key_input_capture;

    localparam int NK  = 4;
    localparam int DEB = 8;

    logic          clk_clk       = 1'b0;
    logic          reset_reset_n = 1'b0;
    logic [NK-1:0] key_n         = '1;
    logic          irq;
    logic [31:0]   rd;

    int n_tests = 0;
    int n_fail  = 0;

    key_input_capture_if avs_if ();

    key_input_capture #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .key_n         (key_n),
        .avs           (avs_if),
        .irq           (irq)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_if.avs_address   = a;
        avs_if.avs_writedata = d;
        avs_if.avs_write     = 1'b1;
        @(negedge clk_clk);
        avs_if.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs_if.avs_address = a;
        avs_if.avs_read    = 1'b1;
        @(negedge clk_clk);
        d = avs_if.avs_readdata;
        avs_if.avs_read    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        avs_if.avs_address   = '0;
        avs_if.avs_read      = 1'b0;
        avs_if.avs_write     = 1'b0;
        avs_if.avs_writedata = '0;

        // Reset state
        step(3);
        reset_reset_n = 1'b1;
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_rdata", avs_if.avs_readdata, 32'h0);
        bus_read(2'd0, rd); check("rst_data", rd, 32'h0);
        bus_read(2'd1, rd); check("rst_addr1", rd, 32'h0);
        bus_read(2'd2, rd); check("rst_mask", rd, 32'h0);
        bus_read(2'd3, rd); check("rst_edge", rd, 32'h0);

        // Glitch rejection: key 0 low for 5 cycles only
        key_n = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("glitch_irq_lo", {31'd0, irq}, 32'h0);
        end
        key_n = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            step(1);
            check("glitch_irq_hi", {31'd0, irq}, 32'h0);
        end
        bus_read(2'd0, rd); check("glitch_data", rd, 32'h0);
        bus_read(2'd3, rd); check("glitch_edge", rd, 32'h0);

        // Clean press of key 1 with mask already enabling it
        bus_write(2'd2, 32'h2);
        key_n = 4'b1101;
        avs_if.avs_address = 2'd0;
        avs_if.avs_read    = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (k == 10) check("press_data_before", avs_if.avs_readdata, 32'h0);
            if (k == 11) check("press_data_after", avs_if.avs_readdata, 32'h2);
            if (k == 11) check("press_irq_before", {31'd0, irq}, 32'h0);
            if (k == 12) check("press_irq_after", {31'd0, irq}, 32'h1);
        end
        avs_if.avs_read = 1'b0;
        bus_read(2'd3, rd); check("press_edge", rd, 32'h2);

        // W1C: irq still high on the clearing edge, low one cycle later
        bus_write(2'd3, 32'h2);
        check("w1c_irq_lag", {31'd0, irq}, 32'h1);
        bus_read(2'd3, rd); check("w1c_edge", rd, 32'h0);
        check("w1c_irq_drop", {31'd0, irq}, 32'h0);

        // Collision: W1C lands on the same edge (11) as a fresh press event
        key_n = 4'b1111;
        step(12);
`ifdef KEY_RELEASE_CAPTURE_EN
        bus_write(2'd1, 32'hF);
`endif
        key_n = 4'b1101;
        step(10);
        bus_write(2'd3, 32'h2);
        check("coll_irq_lag", {31'd0, irq}, 32'h0);
        bus_read(2'd3, rd); check("coll_edge", rd, 32'h2);
        check("coll_irq", {31'd0, irq}, 32'h1);

        // Mask gating: keys 0 and 2 pressed, key 1 still held
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h0);
        key_n = 4'b1000;
        step(12);
        bus_read(2'd3, rd); check("mask_edge", rd, 32'h5);
        check("mask_irq_off", {31'd0, irq}, 32'h0);
        bus_write(2'd2, 32'h4);
        check("mask_irq_lag", {31'd0, irq}, 32'h0);
        step(1);
        check("mask_irq_on", {31'd0, irq}, 32'h1);
        bus_read(2'd2, rd); check("mask_read", rd, 32'h4);

        // Reset while key 3 is mid-count (count 4 after edge 6)
        key_n = 4'b1111;
        step(12);
        key_n = 4'b0111;
        step(6);
        reset_reset_n = 1'b0;
        step(1);
        reset_reset_n = 1'b1;
        // Edge numbering below restarts at the reset-release negedge.
        check("mid_rst_irq", {31'd0, irq}, 32'h0);
        check("mid_rst_rdata", avs_if.avs_readdata, 32'h0);
        bus_read(2'd0, rd); check("mid_rst_data", rd, 32'h0);
        bus_read(2'd2, rd); check("mid_rst_mask", rd, 32'h0);
        bus_read(2'd3, rd); check("mid_rst_edge", rd, 32'h0);
        bus_read(2'd1, rd); check("mid_rst_addr1", rd, 32'h0);
        avs_if.avs_address = 2'd0;
        avs_if.avs_read    = 1'b1;
        for (int k = 5; k <= 11; k++) begin
            step(1);
            if (k == 10) check("post_rst_data_before", avs_if.avs_readdata, 32'h0);
            if (k == 11) check("post_rst_data_after", avs_if.avs_readdata, 32'h8);
        end
        avs_if.avs_read = 1'b0;
        bus_read(2'd3, rd); check("post_rst_edge", rd, 32'h8);
        check("post_rst_irq", {31'd0, irq}, 32'h0);

        // Release of key 3
        key_n = 4'b1111;
        step(12);
`ifdef KEY_RELEASE_CAPTURE_EN
        bus_read(2'd1, rd); check("rel_relcap", rd, 32'h8);
`else
        bus_read(2'd1, rd); check("rel_addr1", rd, 32'h0);
`endif
        bus_read(2'd3, rd); check("rel_edge", rd, 32'h8);
        bus_read(2'd0, rd); check("rel_data", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
